// File: rtl/orbit_frame_sync_pkg.sv
// Shared types and defaults for the Orbita-M8 frame synchroniser.
package orbit_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } sync_state_e;

   localparam int              DEF_WORD_W       = 12;
   localparam int              DEF_FRAME_WORDS  = 1024;
   localparam logic [11:0]     DEF_SYNC_WORD    = 12'hE2B;
   localparam int              DEF_LOCK_CONFIRM = 2;
   localparam int              DEF_LOSS_THRESH  = 3;

   // Width needed to index n items; never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/orbit_frame_sync_if.sv
// Serial input and word-output bundle of the frame synchroniser.
interface orbit_frame_sync_if
   import orbit_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = addr_width(DEF_FRAME_WORDS)
);

   logic              ser_in;
   logic              bit_stb;
   logic [WORD_W-1:0] word_data;
   logic [ADDR_W-1:0] word_addr;
   logic              word_valid;
   logic              frame_start;
   logic              locked;
   logic [15:0]       sync_errors;

   modport master (
      output ser_in, bit_stb,
      input  word_data, word_addr, word_valid, frame_start, locked, sync_errors
   );

   modport slave (
      input  ser_in, bit_stb,
      output word_data, word_addr, word_valid, frame_start, locked, sync_errors
   );

endinterface

// File: rtl/orbit_bit_shifter.sv
// MSB-first deserialiser: shift register plus bit-in-word counter and word-complete pulse.
module orbit_bit_shifter
   import orbit_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_stb,
   input  logic              ser_in,
   input  logic              tracking,
   output logic [WORD_W-1:0] shift_word,
   output logic              word_done
);

   localparam int CNT_W = addr_width(WORD_W);

   logic [WORD_W-1:0] sr;
   logic [CNT_W-1:0]  bit_cnt;

   // Window including the bit arriving this cycle, so decisions need no extra stage.
   assign shift_word = {sr[WORD_W-2:0], ser_in};
   assign word_done  = bit_stb && tracking && (bit_cnt == CNT_W'(WORD_W - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr      <= '0;
         bit_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         if (bit_stb) begin
            sr <= shift_word;
         end
         if (!tracking) begin
            bit_cnt <= '0;
         end else if (bit_stb) begin
            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/orbit_frame_sync.sv
// Orbita-M8 frame synchroniser: hunt/verify/lock flywheel and addressed word output.
// Define ORBIT_SYNC_ERRCNT_EN to build the saturating sync-mismatch counter.
module orbit_frame_sync
   import orbit_pkg::*;
#(
   parameter int              WORD_W       = DEF_WORD_W,
   parameter int              FRAME_WORDS  = DEF_FRAME_WORDS,
   parameter logic [WORD_W-1:0] SYNC_WORD  = WORD_W'(DEF_SYNC_WORD),
   parameter int              LOCK_CONFIRM = DEF_LOCK_CONFIRM,
   parameter int              LOSS_THRESH  = DEF_LOSS_THRESH
) (
   input  logic              clk,
   input  logic              reset,
   orbit_frame_sync_if.slave bus
);

   localparam int ADDR_W = addr_width(FRAME_WORDS);
   localparam int CONF_W = addr_width(LOCK_CONFIRM + 1);
   localparam int MISS_W = addr_width(LOSS_THRESH + 1);

   sync_state_e       state, state_n;
   logic [ADDR_W-1:0] word_cnt, word_cnt_n, word_cnt_inc;
   logic [CONF_W-1:0] confirm, confirm_n, confirm_inc;
   logic [MISS_W-1:0] miss, miss_n, miss_inc;

   logic [WORD_W-1:0] shift_word;
   logic              word_done;
   logic              tracking;
   logic              sync_match;
   logic              sync_check;
   logic              emit;
   logic              sync_miss;

   logic [WORD_W-1:0] word_data_q;
   logic [ADDR_W-1:0] word_addr_q;
   logic              word_valid_q;
   logic              frame_start_q;

   assign tracking = (state != HUNT);

   orbit_bit_shifter #(
      .WORD_W (WORD_W)
   ) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .bit_stb    (bus.bit_stb),
      .ser_in     (bus.ser_in),
      .tracking   (tracking),
      .shift_word (shift_word),
      .word_done  (word_done)
   );

   assign sync_match   = (shift_word == SYNC_WORD);
   assign sync_check   = word_done && (word_cnt == '0);
   assign word_cnt_inc = word_cnt + ADDR_W'(1);
   assign confirm_inc  = confirm + CONF_W'(1);
   assign miss_inc     = miss + MISS_W'(1);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_n    = state;
      word_cnt_n = word_cnt;
      confirm_n  = confirm;
      miss_n     = miss;
      emit       = 1'b0;
      sync_miss  = 1'b0;

      unique case (state)
         HUNT: begin
            // The matching bit is the sync word's last bit; the next word is address 1.
            if (bus.bit_stb && sync_match) begin
               state_n    = VERIFY;
               word_cnt_n = ADDR_W'(1);
               confirm_n  = '0;
            end
         end

         VERIFY: begin
            if (word_done) begin
               word_cnt_n = word_cnt_inc;
               if (sync_check) begin
                  if (!sync_match) begin
                     state_n   = HUNT;
                     sync_miss = 1'b1;
                  end else if (confirm_inc == CONF_W'(LOCK_CONFIRM)) begin
                     state_n = LOCKED;
                     miss_n  = '0;
                     emit    = 1'b1;
                  end else begin
                     confirm_n = confirm_inc;
                  end
               end
            end
         end

         LOCKED: begin
            if (word_done) begin
               word_cnt_n = word_cnt_inc;
               emit       = 1'b1;
               if (sync_check) begin
                  if (sync_match) begin
                     miss_n = '0;
                  end else begin
                     sync_miss = 1'b1;
                     // Flywheel: tolerate isolated bad syncs, drop only on a run of misses.
                     if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                        state_n = HUNT;
                        emit    = 1'b0;
                     end else begin
                        miss_n = miss_inc;
                     end
                  end
               end
            end
         end

         default: state_n = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= HUNT;
         word_cnt      <= '0;
         confirm       <= '0;
         miss          <= '0;
         word_data_q   <= '0;
         word_addr_q   <= '0;
         word_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state         <= state_n;
         word_cnt      <= word_cnt_n;
         confirm       <= confirm_n;
         miss          <= miss_n;
         word_valid_q  <= emit;
         frame_start_q <= emit && (word_cnt == '0);
         if (emit) begin
            word_data_q <= shift_word;
            word_addr_q <= word_cnt;
         end
      end
   end

   assign bus.word_data   = word_data_q;
   assign bus.word_addr   = word_addr_q;
   assign bus.word_valid  = word_valid_q;
   assign bus.frame_start = frame_start_q;
   assign bus.locked      = (state == LOCKED);

`ifdef ORBIT_SYNC_ERRCNT_EN
   logic [15:0] sync_errors_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_errors_q <= '0;
      end else if (sync_miss && (sync_errors_q != 16'hFFFF)) begin
         sync_errors_q <= sync_errors_q + 16'd1;
      end
   end

   assign bus.sync_errors = sync_errors_q;
`else
   logic unused_sync_miss;

   assign unused_sync_miss = sync_miss;
   assign bus.sync_errors  = '0;
`endif

endmodule

// File: tb/tb_orbit_frame_sync.sv
// Randomised bench for orbit_frame_sync: per-cycle check against a bit-position model plus literal pins.
module tb_orbit_frame_sync;

   localparam int          FW           = 32;
   localparam int          AW           = 5;
   localparam logic [11:0] SYNC         = 12'hE2B;
   localparam int          LOCK_CONFIRM = 2;
   localparam int          LOSS_THRESH  = 3;
`ifdef ORBIT_SYNC_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   orbit_frame_sync_if #(.WORD_W(12), .ADDR_W(AW)) bus();

   orbit_frame_sync #(.FRAME_WORDS(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: alignment is a bit position since the acquired sync; words fall every 12 bits.
   logic [11:0] m_win;
   bit          m_aligned, m_lk;
   int          m_bits, m_good, m_bad, m_errs;
   bit          exp_valid, exp_fs, exp_locked;
   logic [11:0] exp_data;
   int          exp_addr, exp_errs;

   logic [11:0] q_data [$];
   int          q_addr [$];
   bit          q_fs   [$];
   bit          q_lk   [$];

   logic [11:0] pay    [FW];
   logic [11:0] c_sync [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_win = '0; m_aligned = 0; m_lk = 0;
      m_bits = 0; m_good = 0; m_bad = 0; m_errs = 0;
      exp_valid = 0; exp_fs = 0; exp_locked = 0;
      exp_data = '0; exp_addr = 0; exp_errs = 0;
   endtask

   task automatic model_step(input bit stb, input bit b);
      int addr;
      bit is_sync, ok, out;
      exp_valid = 0;
      exp_fs    = 0;
      if (stb) begin
         m_win = {m_win[10:0], b};
         if (!m_aligned) begin
            if (m_win == SYNC) begin
               m_aligned = 1; m_bits = 0; m_good = 1;
            end
         end else begin
            m_bits++;
            if (m_bits % 12 == 0) begin
               addr    = (m_bits / 12) % FW;
               is_sync = (addr == 0);
               ok      = (m_win == SYNC);
               out     = m_lk;
               if (is_sync && !ok && m_errs < 65535) m_errs++;
               if (!m_lk) begin
                  if (is_sync) begin
                     if (!ok) m_aligned = 0;
                     else begin
                        m_good++;
                        if (m_good == 1 + LOCK_CONFIRM) begin
                           m_lk = 1; m_bad = 0; out = 1;
                        end
                     end
                  end
               end else if (is_sync) begin
                  if (ok) m_bad = 0;
                  else begin
                     m_bad++;
                     if (m_bad == LOSS_THRESH) begin
                        m_lk = 0; m_aligned = 0; out = 0;
                     end
                  end
               end
               if (out) begin
                  exp_valid = 1; exp_data = m_win; exp_addr = addr; exp_fs = (addr == 0);
               end
            end
         end
      end
      exp_locked = m_lk;
      exp_errs   = ERRCNT ? m_errs : 0;
   endtask

   task automatic compare_step();
      if (!reset) model_reset();
      check("valid",       bus.word_valid,  exp_valid);
      check("frame_start", bus.frame_start, exp_fs);
      check("locked",      bus.locked,      exp_locked);
      check("word_data",   bus.word_data,   exp_data);
      check("word_addr",   bus.word_addr,   exp_addr);
      check("sync_errors", bus.sync_errors, exp_errs);
      if (bus.word_valid === 1'b1) begin
         q_data.push_back(bus.word_data);
         q_addr.push_back(int'(bus.word_addr));
         q_fs.push_back(bus.frame_start);
         q_lk.push_back(bus.locked);
      end
      if (reset) model_step(bus.bit_stb, bus.ser_in);
   endtask

   task automatic cycle(input bit stb, input bit b);
      @(posedge clk);
      #1;
      bus.bit_stb = stb;
      bus.ser_in  = b;
      @(negedge clk);
      compare_step();
   endtask

   task automatic send_word(input logic [11:0] w, input int max_gap);
      for (int i = 11; i >= 0; i--) begin
         int g;
         g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
         repeat (g) cycle(1'b0, 1'($urandom));
         cycle(1'b1, w[i]);
      end
   endtask

   task automatic send_frame(input logic [11:0] sync, input bit rnd, input int max_gap);
      send_word(sync, max_gap);
      for (int k = 1; k < FW; k++) send_word(rnd ? pay[k] : 12'(k), max_gap);
   endtask

   task automatic assert_reset(input bit pin);
      @(posedge clk);
      #1;
      reset       = 1'b0;
      bus.bit_stb = 1'b0;
      #1;
      if (pin) begin
         check("rst_async_valid", bus.word_valid,  0);
         check("rst_async_fs",    bus.frame_start, 0);
         check("rst_async_lock",  bus.locked,      0);
         check("rst_async_data",  bus.word_data,   0);
         check("rst_async_addr",  bus.word_addr,   0);
         check("rst_async_errs",  bus.sync_errors, 0);
      end
      @(negedge clk);
      compare_step();
      repeat (2) cycle(1'b0, 1'b0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset       = 1'b1;
      bus.bit_stb = 1'b0;
      @(negedge clk);
      compare_step();
   endtask

   function automatic int zero_syncs(input int from);
      int n = 0;
      for (int i = from; i < q_data.size(); i++)
         if (q_addr[i] == 0 && q_data[i] == 12'h000 && q_fs[i]) n++;
      return n;
   endfunction

   initial begin
      int s, s2, len1, len2, bad;
      bus.ser_in  = 1'b0;
      bus.bit_stb = 1'b0;
      model_reset();
      for (int k = 0; k < FW; k++) pay[k] = 12'($urandom);
      c_sync[0] = 12'h000; c_sync[1] = SYNC; c_sync[2] = 12'h000;
      c_sync[3] = 12'h000; c_sync[4] = SYNC;

      repeat (3) cycle(1'b0, 1'b0);
      check("rst_valid", bus.word_valid,  0);
      check("rst_lock",  bus.locked,      0);
      check("rst_addr",  bus.word_addr,   0);
      check("rst_errs",  bus.sync_errors, 0);
      release_reset();

      // Clean stream: lock with frame 2 sync, frames 2-3 fully output.
      s = q_data.size();
      for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("a_count", q_data.size() - s, 2 * FW);
      if (q_data.size() > s) begin
         check("a_first_data", q_data[s], SYNC);
         check("a_first_addr", q_addr[s], 0);
         check("a_first_fs",   q_fs[s],   1);
         check("a_first_lock", q_lk[s],   1);
      end
      bad = 0;
      for (int i = s; i < q_data.size(); i++) begin
         if (q_addr[i] != (i - s) % FW) bad++;
         else if (q_addr[i] != 0 && q_data[i] != 12'(q_addr[i])) bad++;
      end
      check("a_order", bad, 0);

      // Fake sync mid-frame while hunting; real sync is off by five words.
      assert_reset(1'b0);
      release_reset();
      s = q_data.size();
      for (int k = 3; k < FW; k++) send_word((k == 5) ? SYNC : 12'(k), 0);
      send_frame(SYNC, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("b_no_valid", q_data.size() - s, 0);
      check("b_locked",   bus.locked, 0);
      check("b_errs",     bus.sync_errors, ERRCNT ? 1 : 0);
      for (int f = 0; f < 3; f++) send_frame(SYNC, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("b_relock", bus.locked, 1);
      check("b_count",  q_data.size() - s, FW);

      // Flywheel: isolated and paired bad syncs are output and tolerated.
      s = q_data.size();
      for (int f = 0; f < 5; f++) send_frame(c_sync[f], 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("c_count",  q_data.size() - s, 5 * FW);
      check("c_zero",   zero_syncs(s), 3);
      check("c_locked", bus.locked, 1);
      check("c_errs",   bus.sync_errors, ERRCNT ? 4 : 0);

      // Three bad syncs in a row: two output, the third drops lock.
      s = q_data.size();
      for (int f = 0; f < 3; f++) send_frame(12'h000, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("d_count",  q_data.size() - s, 2 * FW);
      check("d_zero",   zero_syncs(s), 2);
      check("d_locked", bus.locked, 0);
      check("d_errs",   bus.sync_errors, ERRCNT ? 7 : 0);

      // Same random-payload stream, continuous then with 0-5 cycle strobe gaps.
      assert_reset(1'b0);
      release_reset();
      s = q_data.size();
      for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b1, 0);
      cycle(1'b0, 1'b0);
      len1 = q_data.size() - s;
      check("e_len_cont", len1, 2 * FW);
      assert_reset(1'b0);
      release_reset();
      s2 = q_data.size();
      for (int f = 0; f < 4; f++) send_frame(SYNC, 1'b1, 5);
      cycle(1'b0, 1'b0);
      len2 = q_data.size() - s2;
      check("e_len_gap", len2, 2 * FW);
      bad = 0;
      for (int i = 0; i < len1 && i < len2; i++)
         if (q_data[s + i] !== q_data[s2 + i] || q_addr[s + i] != q_addr[s2 + i]) bad++;
      check("e_gap_same", bad, 0);

      // Reset mid-word while locked, then a full three-sync relock.
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom));
      check("f_pre_lock", bus.locked, 1);
      assert_reset(1'b1);
      release_reset();
      s = q_data.size();
      for (int f = 0; f < 2; f++) send_frame(SYNC, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("f_not_yet",  bus.locked, 0);
      check("f_no_valid", q_data.size() - s, 0);
      send_frame(SYNC, 1'b0, 0);
      cycle(1'b0, 1'b0);
      check("f_locked", bus.locked, 1);
      check("f_count",  q_data.size() - s, FW);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
